// File: rtl/capture_sequencer.sv
// Acquisition sequencer: ring-buffer capture into sample RAM, post-trigger
// counting, then newest-first readback handed bytewise to the UART.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  IDLE      | waiting for arm; config may be loaded
//  ARMED     | writing samples, waiting for run
//  DELAY     | writing samples, counting post-trigger samples
//  RD_ADDR   | present rd_ptr to the RAM
//  RD_WAIT   | RAM data valid, load shift register
//  SEND      | issue tx_start for byte byte_idx once UART idle
//  TX_HOLD   | let busy rise, then wait for UART to finish
module capture_sequencer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_load,
  input  logic [15:0]             cfg_read_count,
  input  logic [15:0]             cfg_delay_count,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    run,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [SAMPLE_WIDTH-1:0] mem_wdata,
  input  logic [SAMPLE_WIDTH-1:0] mem_rdata,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    transmit_busy,
  output logic                    capturing,
  output logic                    done
);

  localparam int NB    = SAMPLE_WIDTH / 8;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_RD_ADDR, S_RD_WAIT, S_SEND, S_TX_HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]             read_cnt_q, read_cnt_d;
  logic [15:0]             delay_cnt_q, delay_cnt_d;
  logic [15:0]             dly_cnt_q, dly_cnt_d;
  logic [15:0]             rd_left_q, rd_left_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]           byte_idx_q, byte_idx_d;
  logic                    hold_q, hold_d;
  logic                    done_q, done_d;
  logic                    start_rd;
  logic [SAMPLE_WIDTH-1:0] sh;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      read_cnt_q  <= '0;
      delay_cnt_q <= '0;
      dly_cnt_q   <= '0;
      rd_left_q   <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      read_cnt_q  <= read_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      rd_left_q   <= rd_left_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    read_cnt_d  = read_cnt_q;
    delay_cnt_d = delay_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    rd_left_d   = rd_left_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    start_rd    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    tx_start    = 1'b0;
    tx_data     = 8'h00;
    sh          = shift_q >> {byte_idx_q, 3'b000};

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_load) begin
            read_cnt_d  = ({16'd0, cfg_read_count} > 32'(DEPTH)) ? 16'(DEPTH) : cfg_read_count;
            delay_cnt_d = cfg_delay_count;
          end
          if (arm) state_d = S_ARMED;
        end
        S_ARMED, S_DELAY: begin
          mem_addr = wr_ptr_q;
          if (sample_valid) begin
            mem_we    = 1'b1;
            mem_wdata = sample_data;
            wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
          end
          if (state_q == S_ARMED) begin
            if (run) begin
              dly_cnt_d = '0;
              if (delay_cnt_q == 16'd0) start_rd = 1'b1;
              else                      state_d  = S_DELAY;
            end
          end else if (sample_valid) begin
            dly_cnt_d = dly_cnt_q + 16'd1;
            if (dly_cnt_d == delay_cnt_q) start_rd = 1'b1;
          end
        end
        S_RD_ADDR: begin
          mem_addr = rd_ptr_q;
          state_d  = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          shift_d    = mem_rdata;
          byte_idx_d = '0;
          state_d    = S_SEND;
        end
        S_SEND: begin
          tx_data = sh[7:0];
          if (!transmit_busy) begin
            tx_start = 1'b1;
            hold_d   = 1'b1;
            state_d  = S_TX_HOLD;
          end
        end
        S_TX_HOLD: begin
          if (hold_q) begin
            hold_d = 1'b0;
          end else if (!transmit_busy) begin
            if (byte_idx_q != BW'(NB - 1)) begin
              byte_idx_d = byte_idx_q + BW'(1);
              state_d    = S_SEND;
            end else begin
              rd_left_d = rd_left_q - 16'd1;
              rd_ptr_d  = rd_ptr_q - ADDR_WIDTH'(1);
              if (rd_left_d == 16'd0) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                state_d = S_RD_ADDR;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      // newest sample is the one just before the (post-write) write pointer
      if (start_rd) begin
        rd_ptr_d  = wr_ptr_d - ADDR_WIDTH'(1);
        rd_left_d = read_cnt_q;
        if (read_cnt_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_ADDR;
        end
      end
    end
  end

  assign capturing = (state_q == S_ARMED) || (state_q == S_DELAY);
  assign done      = done_q;

endmodule
